pipe_ctrl: RTL

- Consumer of the hazard unit's stall request and the execute stage's branch-flush request.
- Produces per-stage enables, bubble injection and flush strobes for the IF/ID/EX front end.
- Downstream stages MA/MO/WB always advance.
- Contains the front-end control FSM, a flush-length counter and a stall watchdog.

---
 rtl/pipe_ctrl_if.sv | 26 ++
 rtl/pipe_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - front-end pipeline control signal bundle
interface pipe_ctrl_if;
  logic        iw_stall;
  logic        iw_flush;
  logic        ow_if_en;
  logic        ow_id_en;
  logic        ow_idex_bubble;
  logic        ow_flush_ifid;
  logic        ow_flush_idex;
  logic        ow_stalled;
  logic        ow_stall_err;
  logic [15:0] ow_stall_cnt;
  logic [15:0] ow_flush_cnt;

  modport master (
    output iw_stall, iw_flush,
    input  ow_if_en, ow_id_en, ow_idex_bubble, ow_flush_ifid, ow_flush_idex,
    input  ow_stalled, ow_stall_err, ow_stall_cnt, ow_flush_cnt
  );

  modport slave (
    input  iw_stall, iw_flush,
    output ow_if_en, ow_id_en, ow_idex_bubble, ow_flush_ifid, ow_flush_idex,
    output ow_stalled, ow_stall_err, ow_stall_cnt, ow_flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - IF/ID/EX stall/flush control FSM with stall watchdog
// Optional statistics counters enabled by defining PIPE_CTRL_STATS_EN.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MAX_STALL    = 7
) (
  input  logic      iw_clk,
  input  logic      iw_rst,
  pipe_ctrl_if.slave pc
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [2:0] FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
  localparam logic [3:0] MAX_STALL_L = 4'(MAX_STALL);

  state_t     state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic [3:0] srun_q;
  logic       err_q;
  logic       do_flush;
  logic       do_stall;
  logic       stalled;

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // fcnt holds the FLUSH-state cycles still to go, counting the current one
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    do_flush = 1'b0;
    do_stall = 1'b0;
    case (state_q)
      FLUSH: begin
        do_flush = 1'b1;
        if (pc.iw_flush) begin
          fcnt_d  = FLUSH_LOAD;
          state_d = (FLUSH_LOAD == 3'd0) ? RUN : FLUSH;
        end else begin
          fcnt_d  = 3'(fcnt_q - 3'd1);
          state_d = (fcnt_q <= 3'd1) ? RUN : FLUSH;
        end
      end
      default: begin
        if (pc.iw_flush) begin
          do_flush = 1'b1;
          fcnt_d   = FLUSH_LOAD;
          state_d  = (FLUSH_LOAD == 3'd0) ? RUN : FLUSH;
        end else if (pc.iw_stall) begin
          do_stall = 1'b1;
          state_d  = STALL;
        end else begin
          state_d  = RUN;
        end
      end
    endcase
  end

  always_comb begin
    pc.ow_if_en       = 1'b1;
    pc.ow_id_en       = 1'b1;
    pc.ow_idex_bubble = 1'b0;
    pc.ow_flush_ifid  = 1'b0;
    pc.ow_flush_idex  = 1'b0;
    pc.ow_stalled     = 1'b0;
    if (iw_rst) begin
      pc.ow_if_en       = 1'b0;
      pc.ow_id_en       = 1'b0;
      pc.ow_idex_bubble = 1'b1;
      pc.ow_flush_ifid  = 1'b1;
      pc.ow_flush_idex  = 1'b1;
    end else if (do_flush) begin
      pc.ow_flush_ifid  = 1'b1;
      pc.ow_flush_idex  = 1'b1;
    end else if (do_stall) begin
      pc.ow_if_en       = 1'b0;
      pc.ow_id_en       = 1'b0;
      pc.ow_idex_bubble = 1'b1;
      pc.ow_stalled     = 1'b1;
    end
  end

  assign stalled = do_stall & ~iw_rst;

  // err fires on the stall cycle that would push the run length past MAX_STALL
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      srun_q <= 4'd0;
      err_q  <= 1'b0;
    end else if (stalled) begin
      if (srun_q != 4'hF) srun_q <= 4'(srun_q + 4'd1);
      if (srun_q >= MAX_STALL_L) err_q <= 1'b1;
    end else begin
      srun_q <= 4'd0;
    end
  end

  assign pc.ow_stall_err = err_q;

`ifdef PIPE_CTRL_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stalled && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (pc.iw_flush && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign pc.ow_stall_cnt = stall_cnt_q;
  assign pc.ow_flush_cnt = flush_cnt_q;
`else
  assign pc.ow_stall_cnt = 16'd0;
  assign pc.ow_flush_cnt = 16'd0;
`endif

endmodule
